mem_arbiter: RTL and testbench
==============================

Name:
mem_arbiter

Overview:
Shares the core's single memory port between the instruction-fetch requester (control FSM MAR/MDR path) and the load/store data requester. Fixed two-requester, one-outstanding-transaction arbiter with round-robin tie-break. All mem_* outputs and requester responses are registered. Sits between the core datapath and the memory/bus interface.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; wmask width is DATA_W/8
TIMEOUT_CYC, 255, max BUSY cycles before abort (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
if_req  in  1  fetch request; held high until if_valid
if_addr  in  ADDR_W  fetch address; stable while if_req high
if_rdata  out  DATA_W  fetch read data; valid with if_valid
if_valid  out  1  one-cycle completion pulse to fetch
if_err  out  1  fetch aborted by timeout; qualifies if_valid
d_req  in  1  data request; held high until d_valid
d_we  in  1  1 = store, 0 = load
d_wmask  in  DATA_W/8  byte write enables for store
d_addr  in  ADDR_W  data address; stable while d_req high
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data; valid with d_valid
d_valid  out  1  one-cycle completion pulse to data side
d_err  out  1  data access aborted by timeout; qualifies d_valid
mem_req  out  1  memory request; held high until mem_valid
mem_we  out  1  memory write enable
mem_wmask  out  DATA_W/8  memory byte enables; 0 for reads
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; sampled with mem_valid
mem_valid  in  1  memory completion; sampled only in BUSY

Behaviour:
- Reset: state=IDLE; all outputs 0; last_grant=DATA, so IF wins the first tie. Reset mid-transaction drops mem_req immediately with no valid pulse. Memory must tolerate an abandoned access.
- States: IDLE, BUSY, RESP.
- IDLE: if exactly one req is high, grant it. If both, grant the one not in last_grant. If none, stay.
- On grant (edge N): latch addr, we, wmask (forced 0 when we=0 or IF), and wdata into mem_*. mem_req=1 from cycle N+1. Update last_grant. Go to BUSY. IF accesses always have mem_we=0.
- BUSY: mem_* are held constant. When mem_valid=1, capture mem_rdata into the grantee's rdata, pulse the grantee's valid for exactly 1 cycle (the next cycle), drop mem_req, and go to RESP. Earliest completion is the first BUSY cycle.
- Minimum request-to-valid latency is 2 cycles (grant edge plus mem_valid in the first BUSY cycle).
- RESP: valid pulse cycle. Requests are ignored here so a requester dropping req this cycle is not re-granted. Unconditionally return to IDLE. Non-grantee rdata and valid are unchanged and 0.
- The x_rdata registers hold their last value until the next completion to that requester.
- mem_valid outside BUSY is ignored.
- A requester dropping req before its valid is a protocol violation; the transaction completes anyway.
- Back-to-back: with both reqs held continuously, grants alternate IF, D, IF, D… Each transaction occupies at least 3 cycles.

Optional Feature:
MEM_ARB_TIMEOUT_EN: a counter clears on entering BUSY and increments each BUSY cycle. When it reaches TIMEOUT_CYC without mem_valid, mem_req drops, the grantee gets a valid pulse with err=1 and rdata=0, and the state goes to RESP. Without the macro, there is no counter, BUSY waits forever, and if_err/d_err are tied 0.

Decomposition:
- Shared package mem_arb_pkg: state enum (IDLE, BUSY, RESP), grant enum (GNT_IF, GNT_DATA), and default width constants.
- Sub-module mem_arb_timer: BUSY-cycle counter with clear/enable inputs and an expired output. Instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
1. IF only: if_req=1, if_addr=0x100; memory returns mem_valid=1 with 0xDEADBEEF after 3 cycles → mem_addr=0x100, mem_we=0, mem_wmask=0; if_valid pulses 1 cycle with if_rdata=0xDEADBEEF; d_valid stays 0.
2. Store: d_req=1, d_we=1, d_wmask=0x3, d_addr=0x2004, d_wdata=0x1234 → mem_we=1, mem_wmask=0x3, mem_addr=0x2004, mem_wdata=0x1234 held until mem_valid; then one d_valid pulse.
3. Tie after reset: both reqs high, immediate mem_valid each time → grant order IF, D, IF, D; each requester's valid arrives every 6 cycles.
4. Reset asserted in BUSY → mem_req=0 asynchronously; no valid pulse. After release, a pending if_req is re-granted and completes normally.
5. MEM_ARB_TIMEOUT_EN with TIMEOUT_CYC=8: d_req load with no mem_valid → after 8 BUSY cycles, d_valid=1, d_err=1, d_rdata=0; a late mem_valid in IDLE is ignored.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF   = 1'b0,
    GNT_DATA = 1'b1
  } gnt_t;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 255;

  // Winner for this arbitration round: a lone requester wins outright,
  // a tie goes to whichever side did not win last time.
  function automatic gnt_t pick_grant(input logic if_req, input logic d_req,
                                      input gnt_t last);
    if (if_req && d_req) return (last == GNT_IF) ? GNT_DATA : GNT_IF;
    return d_req ? GNT_DATA : GNT_IF;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: counts BUSY cycles of the current access; expired marks
// the LIMIT-th BUSY cycle so the access can be abandoned at its end.
module mem_arb_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // Cycle counter: cleared at grant, advances while the access is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && !expired)   cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and
// load/store. One access in flight, round-robin on ties, every output
// registered. Define MEM_ARB_TIMEOUT_EN to abandon accesses that see no
// mem_valid within TIMEOUT_CYC BUSY cycles (completes with err=1, rdata=0).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_wmask,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                d_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_valid
);

  state_t state, state_nxt;
  gnt_t   last_grant, owner, gnt_pick;
  logic   grant, done, abort;

  assign gnt_pick = pick_grant(if_req, d_req, last_grant);

`ifdef MEM_ARB_TIMEOUT_EN
  logic expired;

  mem_arb_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (grant),
    .en      (state == BUSY),
    .expired (expired)
  );

  // A real completion in the expiry cycle still wins over the abort.
  assign abort = expired && !mem_valid;
`else
  // No watchdog: an access waits for mem_valid indefinitely.
  assign abort = 1'b0 & (TIMEOUT_CYC != 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; requests are only looked at in IDLE, so a requester still
  // holding req during its valid cycle is not granted a second time.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (if_req || d_req) begin
        grant     = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (mem_valid || abort) begin
        done      = 1'b1;
        state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side request registers and requester responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GNT_DATA;
      owner      <= GNT_IF;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_wmask  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if (grant) begin
        owner      <= gnt_pick;
        last_grant <= gnt_pick;
        mem_req    <= 1'b1;
        if (gnt_pick == GNT_DATA) begin
          mem_we    <= d_we;
          mem_wmask <= d_we ? d_wmask : '0;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end else begin
          mem_we    <= 1'b0;
          mem_wmask <= '0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end
      end
      if (done) begin
        mem_req <= 1'b0;
        if (owner == GNT_DATA) begin
          d_valid <= 1'b1;
          d_rdata <= abort ? '0 : mem_rdata;
        end else begin
          if_valid <= 1'b1;
          if_rdata <= abort ? '0 : mem_rdata;
        end
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Error flags ride alongside the valid pulse of an abandoned access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_err <= 1'b0;
      d_err  <= 1'b0;
    end else begin
      if_err <= done && abort && (owner == GNT_IF);
      d_err  <= done && abort && (owner == GNT_DATA);
    end
  end
`else
  assign if_err = 1'b0;
  assign d_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed steps plus randomized traffic, checked against a
// transaction-level model (round-robin winner, latched request fields,
// completion one cycle after mem_valid, held rdata).
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO = 8;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TO = 255;
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          if_req, if_valid, if_err, d_req, d_we, d_valid, d_err;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic [MW-1:0] d_wmask, mem_wmask;
  logic          mem_req, mem_we, mem_valid;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wmask(mem_wmask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Model state
  bit            last_d, busy, own_d, resp_edge;
  bit            done_pend, done_d, done_err;
  bit            rand_mode, hold_if, hold_d, force_spur, use_pat;
  int            lat_left, mem_lat, busy_cyc, cyc_n, gnt_cyc;
  logic [DW-1:0] exp_if_rd, exp_d_rd, ret, rd_pat;
  logic [AW-1:0] x_addr;
  logic          x_we;
  logic [MW-1:0] x_mask;
  logic [DW-1:0] x_wdata;
  bit            gq[$];
  int            if_vq[$], d_vq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_d = 1'b1; busy = 1'b0; resp_edge = 1'b0; done_pend = 1'b0;
    exp_if_rd = '0; exp_d_rd = '0;
  endtask

  // One clock: sample at the falling edge, check against the model, then
  // drive memory response and requester inputs for the next rising edge.
  task automatic cyc();
    bit pif, pd;
    pif = if_req; pd = d_req;
    @(negedge clk);
    cyc_n++;
    if (!rst_n) begin
      mem_valid = 1'b0;
      return;
    end
    if (done_pend) begin
      done_pend = 1'b0; busy = 1'b0; resp_edge = 1'b1;
      if (done_d) exp_d_rd = done_err ? '0 : ret;
      else        exp_if_rd = done_err ? '0 : ret;
      chk("if_valid", 64'(if_valid), 64'(!done_d));
      chk("d_valid", 64'(d_valid), 64'(done_d));
      chk("if_err", 64'(if_err), 64'(done_err && !done_d));
      chk("d_err", 64'(d_err), 64'(done_err && done_d));
      chk("mem_req_drop", 64'(mem_req), 64'(0));
      if (done_d) begin d_vq.push_back(cyc_n); d_req = hold_d; end
      else begin if_vq.push_back(cyc_n); if_req = hold_if; end
    end else begin
      chk("no_valid", 64'({if_valid, d_valid, if_err, d_err}), 64'(0));
      if (busy) begin
        chk("mem_req_hold", 64'(mem_req), 64'(1));
        chk("mem_fields_hold", 64'({mem_addr, mem_we, mem_wmask}), 64'({x_addr, x_we, x_mask}));
      end else if (resp_edge) begin
        resp_edge = 1'b0;
        chk("resp_no_grant", 64'(mem_req), 64'(0));
      end else begin
        chk("grant", 64'(mem_req), 64'(pif | pd));
        if (mem_req && (pif | pd)) begin
          own_d = (pif && pd) ? !last_d : pd;
          last_d = own_d; busy = 1'b1; busy_cyc = 0; gnt_cyc = cyc_n;
          gq.push_back(own_d);
          if (rand_mode) mem_lat = $urandom_range(0, 3);
          lat_left = mem_lat;
          if (own_d) begin
            x_addr = d_addr; x_we = d_we; x_mask = d_we ? d_wmask : '0;
          end else begin
            x_addr = if_addr; x_we = 1'b0; x_mask = '0;
          end
          x_wdata = d_wdata;
          chk("mem_addr", 64'(mem_addr), 64'(x_addr));
          chk("mem_we", 64'(mem_we), 64'(x_we));
          chk("mem_wmask", 64'(mem_wmask), 64'(x_mask));
          if (own_d && d_we) chk("mem_wdata", 64'(mem_wdata), 64'(x_wdata));
        end
      end
    end
    chk("if_rdata", 64'(if_rdata), 64'(exp_if_rd));
    chk("d_rdata", 64'(d_rdata), 64'(exp_d_rd));

    // Memory side
    mem_valid = 1'b0;
    mem_rdata = $urandom;
    if (busy && !done_pend) begin
      busy_cyc++;
      if (lat_left == 0) begin
        if (use_pat) mem_rdata = rd_pat;
        mem_valid = 1'b1; ret = mem_rdata;
        done_pend = 1'b1; done_d = own_d; done_err = 1'b0;
      end else begin
        if (lat_left > 0) lat_left--;
        if (TMO_EN && busy_cyc == TO) begin
          done_pend = 1'b1; done_d = own_d; done_err = 1'b1;
        end
      end
    end else if (!busy && (force_spur || (rand_mode && $urandom_range(0, 3) == 0))) begin
      mem_valid = 1'b1;  // outside BUSY: must be ignored
    end

    // Requesters
    if (rand_mode) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom); d_wmask = MW'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((if_req || d_req || busy || done_pend) && n < 200) begin
      cyc(); n++;
    end
    chk("idle_bound", 64'(n < 200), 64'(1));
    cyc(); cyc();
  endtask

  initial begin
    int t0, n;
    if_req = 0; d_req = 0; d_we = 0; mem_valid = 0;
    if_addr = '0; d_addr = '0; d_wmask = '0; d_wdata = '0; mem_rdata = '0;
    rand_mode = 0; hold_if = 0; hold_d = 0; force_spur = 0; use_pat = 0;
    mem_lat = 0; cyc_n = 0; rd_pat = '0;
    model_reset();

    // Reset state
    cyc(); cyc();
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_flags", 64'({mem_we, mem_wmask, if_valid, d_valid, if_err, d_err}), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_rdata", 64'({if_rdata, d_rdata}), 64'(0));
    rst_n = 1;

    // 1: fetch only, memory answers after a few cycles
    use_pat = 1; rd_pat = 32'hDEADBEEF;
    if_addr = 32'h100; if_req = 1; mem_lat = 3; t0 = cyc_n;
    wait_idle();
    chk("t1_latency", 64'(if_vq[$] - t0), 64'(5));
    chk("t1_rdata", 64'(if_rdata), 64'(32'hDEADBEEF));
    chk("t1_no_d", 64'(d_vq.size()), 64'(0));
    use_pat = 0;

    // 2: store with partial byte mask
    d_we = 1; d_wmask = 4'h3; d_addr = 32'h2004; d_wdata = 32'h1234; d_req = 1;
    mem_lat = 2;
    cyc(); cyc();
    chk("t2_mem_wdata", 64'(mem_wdata), 64'(32'h1234));
    chk("t2_mem_wmask", 64'(mem_wmask), 64'(4'h3));
    wait_idle();
    chk("t2_one_d", 64'(d_vq.size()), 64'(1));

    // 3: both held continuously, immediate completions
    gq.delete(); if_vq.delete(); d_vq.delete();
    d_we = 0; if_addr = 32'h200; d_addr = 32'h3000;
    hold_if = 1; hold_d = 1; if_req = 1; d_req = 1; mem_lat = 0;
    repeat (20) cyc();
    hold_if = 0; hold_d = 0;
    wait_idle();
    chk("t3_ngrants", 64'(gq.size() >= 4), 64'(1));
    chk("t3_order", 64'({gq[0], gq[1], gq[2], gq[3]}), 64'(4'b0101));
    chk("t3_if_period", 64'(if_vq[1] - if_vq[0]), 64'(6));
    chk("t3_d_period", 64'(d_vq[1] - d_vq[0]), 64'(6));

    // 4: reset while BUSY, pending fetch re-granted afterwards
    if_addr = 32'h300; if_req = 1; mem_lat = 5;
    cyc(); cyc();
    chk("t4_busy", 64'(mem_req), 64'(1));
    #2 rst_n = 0;
    #1;
    chk("t4_async_drop", 64'(mem_req), 64'(0));
    chk("t4_no_valid", 64'({if_valid, d_valid}), 64'(0));
    model_reset();
    cyc(); cyc();
    rst_n = 1; mem_lat = 1; n = if_vq.size();
    wait_idle();
    chk("t4_regrant", 64'(if_vq.size()), 64'(n + 1));

    // Randomized traffic
    rand_mode = 1;
    repeat (600) cyc();
    rand_mode = 0;
    wait_idle();

`ifdef MEM_ARB_TIMEOUT_EN
    // 5: load with no memory answer, then a stray mem_valid in IDLE
    d_we = 0; d_addr = 32'h40; d_req = 1; mem_lat = -1; n = d_vq.size();
    wait_idle();
    chk("t5_done", 64'(d_vq.size()), 64'(n + 1));
    chk("t5_latency", 64'(d_vq[$] - gnt_cyc), 64'(TO));
    chk("t5_rdata", 64'(d_rdata), 64'(0));
    force_spur = 1; cyc(); force_spur = 0;
    repeat (3) cyc();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
